// File: rtl/amba_apb_pkg.sv
// Shared constants and FSM state encoding for the APB completer slice.
// States are plain localparams so older code can consume the encoding unchanged.
package amba_apb_pkg;

   localparam int unsigned DEF_ADDR_W      = 8;
   localparam int unsigned DEF_DATA_W      = 8;
   localparam int unsigned DEF_DEPTH       = 16;
   localparam int unsigned DEF_WAIT_STATES = 1;
   localparam logic [7:0]  DEF_ID_VALUE    = 8'hA5;

   // Wide enough for the maximum of 15 wait states.
   localparam int unsigned CNT_W = 4;

   typedef logic [1:0] apb_state_t;

   localparam apb_state_t StIdle   = 2'd0;
   localparam apb_state_t StSetup  = 2'd1;
   localparam apb_state_t StAccess = 2'd2;

endpackage

// File: rtl/amba_apb_regfile.sv
// Register storage: one write port with enable, one combinational read port,
// asynchronous active-low clear. Out-of-range reads return zero.
module amba_apb_regfile #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned     IDX_W     = $clog2(DEPTH);
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (we && ({1'b0, waddr} < DEPTH_EXT)) begin
         mem_q[waddr[IDX_W-1:0]] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      if ({1'b0, raddr} < DEPTH_EXT) begin
         rdata = mem_q[raddr[IDX_W-1:0]];
      end
   end

endmodule

// File: rtl/amba_apb_completer.sv
// APB completer with a small register file, a read-only ID at address 0 and a
// configurable number of wait states. All bus outputs are registered.
module amba_apb_completer
   import amba_apb_pkg::*;
#(
   parameter int unsigned       ADDR_W      = DEF_ADDR_W,
   parameter int unsigned       DATA_W      = DEF_DATA_W,
   parameter int unsigned       DEPTH       = DEF_DEPTH,
   parameter int unsigned       WAIT_STATES = DEF_WAIT_STATES,
   parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(DEF_ID_VALUE)
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr
);

   localparam logic [CNT_W-1:0] WS_CNT    = CNT_W'(WAIT_STATES);
   localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   apb_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              pready_q, pready_d;
   logic              pslverr_q, pslverr_d;
   logic [DATA_W-1:0] prdata_q, prdata_d;

   logic              rf_we;
   logic [DATA_W-1:0] rf_rdata;
   logic [ADDR_W-1:0] resp_addr;
   logic              resp_write;
   logic              resp_err;
   logic              resp_en;
   logic [DATA_W-1:0] rd_val;

   // With zero wait states the response is built on the SETUP edge, before the
   // latched copies exist, so the live bus values feed the response path there.
   assign resp_addr  = (state_q == StIdle) ? paddr  : addr_q;
   assign resp_write = (state_q == StIdle) ? pwrite : write_q;
   assign resp_err   = ({1'b0, resp_addr} >= DEPTH_EXT) || (resp_write && (resp_addr == '0));
   assign rd_val     = (resp_addr == '0) ? ID_VALUE : rf_rdata;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      resp_en = 1'b0;
      rf_we   = 1'b0;
      case (state_q)
         StIdle: begin
            if (psel && !penable) begin
               state_d = StSetup;
               cnt_d   = '0;
               addr_d  = paddr;
               write_d = pwrite;
               wdata_d = pwdata;
               resp_en = (WS_CNT == '0);
            end
         end
         StSetup, StAccess: begin
            if (!(psel && penable)) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (pready_q) begin
               state_d = StIdle;
               cnt_d   = '0;
               rf_we   = write_q && !resp_err;
            end else begin
               state_d = StAccess;
               cnt_d   = cnt_q + 1'b1;
               resp_en = (cnt_d == WS_CNT);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      pready_d  = resp_en;
      pslverr_d = resp_en && resp_err;
      prdata_d  = '0;
      if (resp_en && !resp_err && !resp_write) begin
         prdata_d = rd_val;
      end
   end

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   assign pready  = pready_q;
   assign pslverr = pslverr_q;
   assign prdata  = prdata_q;

   amba_apb_regfile #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_regfile (
      .clk   (pclk),
      .rst_n (preset),
      .we    (rf_we),
      .waddr (addr_q),
      .wdata (wdata_q),
      .raddr (resp_addr),
      .rdata (rf_rdata)
   );

endmodule

// File: tb/tb_amba_apb_completer.sv
// Bench for amba_apb_completer: one instance with one wait state, one with none,
// sharing the bus except psel, checked against an array model of the register map.
module tb_amba_apb_completer;

   logic       pclk;
   logic       preset;
   logic       psel_a, psel_b;
   logic       penable;
   logic       pwrite;
   logic [7:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata_a, prdata_b;
   logic       pready_a, pready_b;
   logic       pslverr_a, pslverr_b;

   int checks = 0;
   int errors = 0;

   // Expected register contents per instance (index 1 = one wait state, 0 = none).
   logic [7:0] mem [2][256];

   amba_apb_completer #(
      .WAIT_STATES (1)
   ) u_ws1 (
      .pclk    (pclk),
      .preset  (preset),
      .psel    (psel_a),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .prdata  (prdata_a),
      .pready  (pready_a),
      .pslverr (pslverr_a)
   );

   amba_apb_completer #(
      .WAIT_STATES (0)
   ) u_ws0 (
      .pclk    (pclk),
      .preset  (preset),
      .psel    (psel_b),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .prdata  (prdata_b),
      .pready  (pready_b),
      .pslverr (pslverr_b)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #2_000_000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] obs_rdata(input int ws);
      return (ws == 1) ? prdata_a : prdata_b;
   endfunction

   function automatic logic obs_ready(input int ws);
      return (ws == 1) ? pready_a : pready_b;
   endfunction

   function automatic logic obs_err(input int ws);
      return (ws == 1) ? pslverr_a : pslverr_b;
   endfunction

   task automatic drive_sel(input int ws, input logic on);
      psel_a = on && (ws == 1);
      psel_b = on && (ws == 0);
   endtask

   task automatic idle();
      psel_a  = 1'b0;
      psel_b  = 1'b0;
      penable = 1'b0;
      @(posedge pclk);
      #1;
   endtask

   task automatic clear_model();
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 256; i++) begin
            mem[w][i] = 8'h00;
         end
      end
   endtask

   // One complete transfer; entered and left 1 time unit after a rising edge.
   // ws is the wait-state count of the addressed instance.
   task automatic xfer(input int ws, input logic wr, input logic [7:0] a, input logic [7:0] d);
      logic       exp_err;
      logic [7:0] exp_rd;
      exp_err = (a >= 8'd16) || (wr && (a == 8'd0));
      if (wr || exp_err)  exp_rd = 8'h00;
      else if (a == 8'd0) exp_rd = 8'hA5;
      else                exp_rd = mem[ws][a];
      drive_sel(ws, 1'b1);
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = d;
      @(negedge pclk);
      check("setup_pready", 32'(obs_ready(ws)), 32'd0);
      @(posedge pclk);
      #1;
      penable = 1'b1;
      // Bus values during ACCESS must not matter.
      paddr   = 8'($urandom);
      pwdata  = 8'($urandom);
      pwrite  = 1'($urandom);
      for (int i = 0; i < ws; i++) begin
         @(negedge pclk);
         check("wait_pready", 32'(obs_ready(ws)), 32'd0);
         check("wait_prdata", 32'(obs_rdata(ws)), 32'd0);
         @(posedge pclk);
         #1;
      end
      @(negedge pclk);
      check("done_pready", 32'(obs_ready(ws)), 32'd1);
      check("done_pslverr", 32'(obs_err(ws)), 32'(exp_err));
      check("done_prdata", 32'(obs_rdata(ws)), 32'(exp_rd));
      @(posedge pclk);
      #1;
      penable = 1'b0;
      if (wr && !exp_err) mem[ws][a] = d;
   endtask

   initial begin
      int         ws;
      logic       wr;
      logic [7:0] a;
      int         r;

      clear_model();
      preset  = 1'b0;
      psel_a  = 1'b0;
      psel_b  = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = 8'h00;
      pwdata  = 8'h00;
      @(posedge pclk);
      @(negedge pclk);
      for (int w = 0; w < 2; w++) begin
         check("rst_pready", 32'(obs_ready(w)), 32'd0);
         check("rst_pslverr", 32'(obs_err(w)), 32'd0);
         check("rst_prdata", 32'(obs_rdata(w)), 32'd0);
      end
      preset = 1'b1;
      @(posedge pclk);
      #1;

      // Basic write/readback with one wait state.
      xfer(1, 1'b1, 8'd5, 8'h3C);
      xfer(1, 1'b0, 8'd5, 8'h00);
      idle();

      // ID register is read-only.
      xfer(1, 1'b0, 8'd0, 8'h00);
      xfer(1, 1'b1, 8'd0, 8'hFF);
      xfer(1, 1'b0, 8'd0, 8'h00);

      // Out-of-range address, full-width compare.
      xfer(1, 1'b0, 8'h20, 8'h00);
      xfer(1, 1'b1, 8'h20, 8'h11);
      xfer(1, 1'b0, 8'd5, 8'h00);
      idle();

      // Zero wait states, back-to-back.
      xfer(0, 1'b1, 8'd1, 8'h01);
      xfer(0, 1'b1, 8'd2, 8'h02);
      xfer(0, 1'b1, 8'd3, 8'h03);
      xfer(0, 1'b0, 8'd1, 8'h00);
      xfer(0, 1'b0, 8'd2, 8'h00);
      xfer(0, 1'b0, 8'd3, 8'h00);
      idle();

      // psel dropped in ACCESS: no completion, no write.
      drive_sel(1, 1'b1);
      pwrite = 1'b1;
      paddr  = 8'd4;
      pwdata = 8'h77;
      @(posedge pclk);
      #1;
      drive_sel(1, 1'b0);
      penable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge pclk);
         check("abort_pready", 32'(pready_a), 32'd0);
         @(posedge pclk);
         #1;
      end
      idle();
      xfer(1, 1'b0, 8'd4, 8'h00);
      idle();

      // Randomized traffic on both instances.
      for (int n = 0; n < 80; n++) begin
         ws = int'($urandom_range(0, 1));
         wr = 1'($urandom);
         r  = int'($urandom_range(0, 9));
         if (r == 0)      a = 8'h20;
         else if (r == 1) a = 8'($urandom);
         else             a = 8'($urandom_range(0, 15));
         xfer(ws, wr, a, 8'($urandom));
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();

      // Reset during the completing cycle of a write to address 6.
      xfer(0, 1'b1, 8'd1, 8'h5A);
      drive_sel(1, 1'b1);
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 8'd6;
      pwdata  = 8'h66;
      @(posedge pclk);
      #1;
      penable = 1'b1;
      @(negedge pclk);
      check("rstmid_wait_pready", 32'(pready_a), 32'd0);
      @(posedge pclk);
      #1;
      @(negedge pclk);
      check("rstmid_pre_pready", 32'(pready_a), 32'd1);
      #1;
      preset = 1'b0;
      #1;
      for (int w = 0; w < 2; w++) begin
         check("rstmid_pready", 32'(obs_ready(w)), 32'd0);
         check("rstmid_pslverr", 32'(obs_err(w)), 32'd0);
         check("rstmid_prdata", 32'(obs_rdata(w)), 32'd0);
      end
      @(posedge pclk);
      #1;
      drive_sel(0, 1'b0);
      penable = 1'b0;
      @(negedge pclk);
      preset = 1'b1;
      clear_model();
      @(posedge pclk);
      #1;
      xfer(1, 1'b0, 8'd6, 8'h00);
      xfer(0, 1'b0, 8'd1, 8'h00);
      xfer(1, 1'b0, 8'd0, 8'h00);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
